// File: rtl/step_exec_controller.sv
// Sequencer for the 4-bit datapath. It synchronises the step and switch buttons,
// fetches an instruction or takes one from the switches, and drives the RF, ALU and dmem controls.
module step_exec_controller #(
    parameter  int unsigned IM_AW   = 4,
    parameter  int unsigned RF_AW   = 3,
    localparam int unsigned INSTR_W = 12,
    localparam int unsigned DM_AW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left_btn,
    input  logic               right_btn,
    input  logic               switch_en,
    input  logic [INSTR_W-1:0] switch_instr,
    input  logic [INSTR_W-1:0] im_rdata,
    output logic [IM_AW-1:0]   im_addr,
    output logic [IM_AW-1:0]   pc,
    output logic [INSTR_W-1:0] instr,
    output logic [RF_AW-1:0]   rf_ra1,
    output logic [RF_AW-1:0]   rf_ra2,
    output logic [RF_AW-1:0]   rf_waddr,
    output logic               rf_we,
    output logic [1:0]         rf_wsel,
    output logic               alu_op,
    output logic [DM_AW-1:0]   dm_addr,
    output logic               dm_we,
    output logic [DM_AW-1:0]   imm,
    output logic               busy,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
    } state_e;

    localparam logic [2:0] OP_STORE = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_LDI   = 3'd4;
    localparam logic [2:0] OP_NOP0  = 3'd5;
    localparam logic [2:0] OP_NOP1  = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    state_e             state_q, state_d;
    logic [1:0]         prime_q;
    logic               l_s1_q, l_s2_q, l_prev_q;
    logic               r_s1_q, r_s2_q, r_prev_q;
    logic               l_pulse, r_pulse;
    logic [IM_AW-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d, new_instr;
    logic               load_instr;
    logic [2:0]         op_q, new_op;
    logic               new_alu;
    logic [RF_AW-1:0]   ra1_q, ra1_d, ra2_q, ra2_d, waddr_q, waddr_d;
    logic [1:0]         wsel_q, wsel_d;
    logic               alu_op_q, alu_op_d;
    logic [DM_AW-1:0]   dm_addr_q, dm_addr_d, imm_q, imm_d;
    logic               rf_we_q, rf_we_d, dm_we_q, dm_we_d;
    logic               busy_q, busy_d, halted_q, halted_d;

    // prev holds 1 until s2 carries a real post-reset sample, so a held button never steps
    assign l_pulse = l_s2_q & ~l_prev_q;
    assign r_pulse = r_s2_q & ~r_prev_q;
    assign op_q    = instr_q[11:9];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ra1_d      = ra1_q;
        ra2_d      = ra2_q;
        waddr_d    = waddr_q;
        wsel_d     = wsel_q;
        alu_op_d   = alu_op_q;
        dm_addr_d  = dm_addr_q;
        imm_d      = imm_q;
        rf_we_d    = 1'b0;
        dm_we_d    = 1'b0;
        load_instr = 1'b0;
        new_instr  = instr_q;

        case (state_q)
            S_IDLE: begin
                if (l_pulse) begin
                    state_d = S_FETCH;
                end else if (r_pulse && switch_en) begin
                    state_d    = S_DECODE;
                    load_instr = 1'b1;
                    new_instr  = switch_instr;
                end
            end
            S_FETCH: begin
                state_d    = S_DECODE;
                load_instr = 1'b1;
                new_instr  = im_rdata;
                pc_d       = pc_q + IM_AW'(1);
            end
            S_DECODE: begin
                if (op_q == OP_HALT)                         state_d = S_HALTED;
                else if (op_q == OP_NOP0 || op_q == OP_NOP1) state_d = S_IDLE;
                else                                         state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
                rf_we_d = (op_q == OP_LOAD) || (op_q == OP_ADD) ||
                          (op_q == OP_SUB)  || (op_q == OP_LDI);
                dm_we_d = (op_q == OP_STORE);
            end
            S_WB:     state_d = S_IDLE;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase

        // Field outputs are registered as the instruction is latched, so they are valid in DECODE
        new_op  = new_instr[11:9];
        new_alu = (new_op == OP_ADD) || (new_op == OP_SUB);
        if (load_instr) begin
            instr_d   = new_instr;
            ra1_d     = new_alu ? new_instr[5:3] : new_instr[8:6];
            ra2_d     = new_alu ? new_instr[2:0] : new_instr[5:3];
            waddr_d   = new_instr[8:6];
            alu_op_d  = (new_op == OP_SUB);
            dm_addr_d = new_instr[3:0];
            imm_d     = new_instr[3:0];
            if (new_alu)                wsel_d = 2'd1;
            else if (new_op == OP_LDI)  wsel_d = 2'd2;
            else                        wsel_d = 2'd0;
        end

        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                   (state_d == S_EXEC)  || (state_d == S_WB);
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            prime_q   <= 2'b00;
            l_s1_q    <= 1'b0;
            l_s2_q    <= 1'b0;
            l_prev_q  <= 1'b1;
            r_s1_q    <= 1'b0;
            r_s2_q    <= 1'b0;
            r_prev_q  <= 1'b1;
            pc_q      <= '0;
            instr_q   <= '0;
            ra1_q     <= '0;
            ra2_q     <= '0;
            waddr_q   <= '0;
            wsel_q    <= '0;
            alu_op_q  <= 1'b0;
            dm_addr_q <= '0;
            imm_q     <= '0;
            rf_we_q   <= 1'b0;
            dm_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prime_q   <= {prime_q[0], 1'b1};
            l_s1_q    <= left_btn;
            l_s2_q    <= l_s1_q;
            l_prev_q  <= prime_q[1] ? l_s2_q : 1'b1;
            r_s1_q    <= right_btn;
            r_s2_q    <= r_s1_q;
            r_prev_q  <= prime_q[1] ? r_s2_q : 1'b1;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ra1_q     <= ra1_d;
            ra2_q     <= ra2_d;
            waddr_q   <= waddr_d;
            wsel_q    <= wsel_d;
            alu_op_q  <= alu_op_d;
            dm_addr_q <= dm_addr_d;
            imm_q     <= imm_d;
            rf_we_q   <= rf_we_d;
            dm_we_q   <= dm_we_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    assign im_addr  = pc_q;
    assign pc       = pc_q;
    assign instr    = instr_q;
    assign rf_ra1   = ra1_q;
    assign rf_ra2   = ra2_q;
    assign rf_waddr = waddr_q;
    assign rf_wsel  = wsel_q;
    assign alu_op   = alu_op_q;
    assign dm_addr  = dm_addr_q;
    assign imm      = imm_q;
    assign rf_we    = rf_we_q;
    assign dm_we    = dm_we_q;
    assign busy     = busy_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_step_exec_controller.sv
// Bench for step_exec_controller: transaction-level model of press -> step -> outputs,
// compared every cycle, plus directed literal checks and a randomized button/switch phase.
module tb_step_exec_controller;

    logic        clk = 1'b0;
    logic        reset, left_btn, right_btn, switch_en;
    logic [11:0] switch_instr, im_rdata;
    logic [3:0]  im_addr, pc;
    logic [11:0] instr;
    logic [2:0]  rf_ra1, rf_ra2, rf_waddr;
    logic        rf_we, alu_op, dm_we, busy, halted;
    logic [1:0]  rf_wsel;
    logic [3:0]  dm_addr, imm;

    logic [11:0] imem [16];
    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;
    int rf_we_n = 0;
    int dm_we_n = 0;

    step_exec_controller dut (
        .clk(clk), .reset(reset), .left_btn(left_btn), .right_btn(right_btn),
        .switch_en(switch_en), .switch_instr(switch_instr), .im_rdata(im_rdata),
        .im_addr(im_addr), .pc(pc), .instr(instr), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_waddr(rf_waddr), .rf_we(rf_we), .rf_wsel(rf_wsel), .alu_op(alu_op),
        .dm_addr(dm_addr), .dm_we(dm_we), .imm(imm), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) im_rdata <= imem[im_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Decode rules: ADD/SUB read r2,r3; others read r1 (and r2); wsel 0=dmem 1=alu 2=imm
    function automatic logic [31:0] exp_fields(input logic [11:0] i);
        logic [2:0] op;
        logic       alu;
        logic [1:0] ws;
        op  = i[11:9];
        alu = (op == 3'd2) || (op == 3'd3);
        ws  = alu ? 2'd1 : (op == 3'd4) ? 2'd2 : 2'd0;
        return {i, alu ? i[5:3] : i[8:6], alu ? i[2:0] : i[5:3], i[8:6], ws,
                op == 3'd3, i[3:0], i[3:0]};
    endfunction

    function automatic bit short_op(input logic [2:0] op);
        return op >= 3'd5;
    endfunction

    // Model: remaining busy cycles, pc, current instruction, press delay lines
    int          m_left = 0;
    int          m_pc = 0;
    bit          m_halted = 0;
    logic [11:0] m_instr = '0;
    logic [11:0] pend_instr = '0;
    bit          pend = 0;
    bit          l_last = 1, r_last = 1, l_d1 = 0, l_d2 = 0, r_d1 = 0, r_d2 = 0;

    task automatic model_reset();
        m_left = 0; m_pc = 0; m_halted = 0; m_instr = '0; pend = 0;
        l_last = 1; r_last = 1; l_d1 = 0; l_d2 = 0; r_d1 = 0; r_d2 = 0;
    endtask

    task automatic model_step();
        bit l_go, r_go, idle_before;
        l_go = l_d2; r_go = r_d2;
        l_d2 = l_d1; r_d2 = r_d1;
        l_d1 = left_btn & ~l_last;
        r_d1 = right_btn & ~r_last;
        l_last = left_btn; r_last = right_btn;
        idle_before = (m_left == 0) && !m_halted;
        if (pend) begin
            m_instr = pend_instr;
            m_pc    = (m_pc + 1) % 16;
            pend    = 0;
        end
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_instr[11:9] == 3'd7) m_halted = 1;
        end
        if (idle_before && l_go) begin
            pend_instr = imem[m_pc];
            pend       = 1;
            m_left     = short_op(imem[m_pc][11:9]) ? 2 : 4;
        end else if (idle_before && r_go && switch_en) begin
            m_instr = switch_instr;
            m_left  = short_op(switch_instr[11:9]) ? 1 : 3;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) model_reset();
        else        model_step();
    end

    // Every-cycle comparison against the model
    initial forever begin
        logic [2:0] eop;
        logic [3:0] ectl;
        @(negedge clk);
        if (cmp_en) begin
            eop  = m_instr[11:9];
            ectl = {m_left != 0, m_halted,
                    (m_left == 1) && (eop >= 3'd1) && (eop <= 3'd4),
                    (m_left == 1) && (eop == 3'd0)};
            chk("cyc_ctrl", 32'({busy, halted, rf_we, dm_we}), 32'(ectl));
            chk("cyc_pc", 32'({im_addr, pc}), 32'({4'(m_pc), 4'(m_pc)}));
            chk("cyc_fields", {instr, rf_ra1, rf_ra2, rf_waddr, rf_wsel, alu_op, dm_addr, imm},
                exp_fields(m_instr));
        end
    end

    initial forever begin
        @(negedge clk);
        if (rf_we) rf_we_n++;
        if (dm_we) dm_we_n++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press_left();
        left_btn = 1'b1; idle(2); left_btn = 1'b0;
    endtask

    task automatic press_right();
        right_btn = 1'b1; idle(2); right_btn = 1'b0;
    endtask

    task automatic wait_we(input string name, input int lim);
        bit hit;
        hit = 0;
        for (int i = 0; i < lim && !hit; i++) begin
            tick();
            if (rf_we || dm_we) hit = 1;
        end
        chk({name, "_we_seen"}, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0; idle(3); reset = 1'b1; idle(4);
    endtask

    initial begin
        int we0;
        bit seen;
        logic [11:0] v;
        reset = 1'b0; left_btn = 1'b1; right_btn = 1'b0;
        switch_en = 1'b0; switch_instr = '0;
        for (int i = 0; i < 16; i++) imem[i] = 12'hA00;
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;

        // T1: button held through reset never steps
        idle(2); reset = 1'b1; idle(10);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_pc", 32'(pc), 0);
        chk("t1_instr", 32'(instr), 0);
        left_btn = 1'b0; idle(4);
        chk("t1_rf_we_count", 32'(rf_we_n), 0);

        // T2: LDI R1,4 fetched from imem[0]
        imem[0] = 12'h844;
        press_left();
        wait_we("t2", 20);
        chk("t2_rf_we", 32'(rf_we), 1);
        chk("t2_waddr", 32'(rf_waddr), 1);
        chk("t2_wsel", 32'(rf_wsel), 2);
        chk("t2_imm", 32'(imm), 4);
        idle(3);
        chk("t2_pc", 32'(pc), 1);

        // T3: ADD R1,R2,R3 from the switches, pc untouched
        switch_en = 1'b1; switch_instr = 12'h453;
        press_right();
        wait_we("t3", 20);
        chk("t3_alu_op", 32'(alu_op), 0);
        chk("t3_ra1", 32'(rf_ra1), 2);
        chk("t3_ra2", 32'(rf_ra2), 3);
        chk("t3_wsel", 32'(rf_wsel), 1);
        idle(3);
        chk("t3_pc", 32'(pc), 1);

        // T4: simultaneous presses -> fetch wins; press while busy dropped
        imem[1] = 12'h887;
        we0 = rf_we_n;
        left_btn = 1'b1; right_btn = 1'b1; idle(2);
        left_btn = 1'b0; right_btn = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (busy) seen = 1;
            else tick();
        end
        chk("t4_busy_seen", 32'(seen), 1);
        press_left();
        idle(15);
        chk("t4_we_count", 32'(rf_we_n - we0), 1);
        chk("t4_pc", 32'(pc), 2);
        chk("t4_instr", 32'(instr), 32'h887);
        chk("t4_waddr", 32'(rf_waddr), 2);
        chk("t4_imm", 32'(imm), 7);
        switch_en = 1'b0;

        // T5: walk pc to 15 with NOPs, STORE at 15 wraps pc to 0
        for (int i = 0; i < 16; i++) imem[i] = 12'hA00;
        imem[15] = 12'h045;
        for (int i = 0; i < 13; i++) begin
            press_left(); idle(5);
        end
        chk("t5_pc15", 32'(pc), 15);
        we0 = rf_we_n;
        press_left();
        wait_we("t5", 20);
        chk("t5_dm_we", 32'(dm_we), 1);
        chk("t5_dm_addr", 32'(dm_addr), 5);
        chk("t5_rf_we", 32'(rf_we), 0);
        idle(3);
        chk("t5_pc_wrap", 32'(pc), 0);
        chk("t5_rf_we_count", 32'(rf_we_n - we0), 0);

        // Randomized presses, switch instructions and imem (HALT kept out)
        for (int i = 0; i < 16; i++) begin
            v = 12'($urandom);
            if (v[11:9] == 3'd7) v[11:9] = 3'd5;
            imem[i] = v;
        end
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 5) == 0) left_btn  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) right_btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) switch_en = 1'($urandom_range(0, 1));
            v = 12'($urandom);
            if (v[11:9] == 3'd7) v[11:9] = 3'd6;
            switch_instr = v;
            tick();
        end
        left_btn = 1'b0; right_btn = 1'b0; switch_en = 1'b0;
        idle(10);

        // T6: HALT sticks until reset; reset mid-WB kills the write
        do_reset();
        imem[0] = 12'hE00;
        press_left(); idle(8);
        chk("t6_halted", 32'(halted), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pc", 32'(pc), 1);
        switch_en = 1'b1; switch_instr = 12'h844;
        press_left(); idle(2); press_right(); idle(10);
        chk("t6_still_halted", 32'(halted), 1);
        chk("t6_pc_held", 32'(pc), 1);
        chk("t6_instr_held", 32'(instr), 32'hE00);
        switch_en = 1'b0;
        do_reset();
        chk("t6_unhalted", 32'(halted), 0);
        chk("t6_pc_reset", 32'(pc), 0);
        imem[0] = 12'h844;
        press_left();
        wait_we("t6", 20);
        reset = 1'b0;
        #1;
        chk("t6_abort_rf_we", 32'(rf_we), 0);
        chk("t6_abort_busy", 32'(busy), 0);
        chk("t6_abort_pc", 32'(pc), 0);
        idle(3); reset = 1'b1; idle(8);
        chk("t6_after_busy", 32'(busy), 0);
        chk("t6_after_pc", 32'(pc), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
